// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage.
// Holds the funct3 encodings of the memory access types, the base byte-mask helper used
// for store alignment, and the alignment rule shared by loads and stores.
package mem_wb_stage_pkg;

  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  // Access size lives in funct3[1:0]. Signed and unsigned variants share a size.
  function automatic logic [3:0] byte_mask(input logic [2:0] mem_type);
    case (mem_type[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // A halfword must be 2-byte aligned and a word must be 4-byte aligned.
  function automatic logic is_misaligned(input logic [2:0] mem_type, input logic [1:0] offset);
    case (mem_type[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_ram_dp.sv
// True dual-port data RAM with per-byte write enables, read-first on both ports.
// Ports:
//   clk                        rising-edge clock shared by both ports
//   addr_a_i/we_a_i/din_a_i    port A word index, byte enables, write data (CPU)
//   dout_a_o                   port A read data, one cycle after the address
//   addr_b_i/we_b_i/din_b_i    port B word index, byte enables, write data (debug)
//   dout_b_o                   port B read data, one cycle after the address
// When both ports write the same byte in one cycle, port A's data is kept.
module data_ram_dp #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a_i,
  input  logic [3:0]    we_a_i,
  input  logic [31:0]   din_a_i,
  output logic [31:0]   dout_a_o,
  input  logic [AW-1:0] addr_b_i,
  input  logic [3:0]    we_b_i,
  input  logic [31:0]   din_b_i,
  output logic [31:0]   dout_b_o
);

  // NOTE: the array has no reset branch on purpose; resetting it would prevent block RAM inference.
  logic [31:0] mem_q [WORDS];
  logic [31:0] dout_a_q;
  logic [31:0] dout_b_q;

  // NOTE: non-blocking assignments sample the old word before any write lands, which is
  // exactly read-first behaviour; blocking writes here would turn it into write-first.
  always_ff @(posedge clk) begin
    dout_a_q <= mem_q[addr_a_i];
    dout_b_q <= mem_q[addr_b_i];
    for (int i = 0; i < 4; i++) begin
      if (we_b_i[i]) mem_q[addr_b_i][8*i +: 8] <= din_b_i[8*i +: 8];
    end
    // Port A is written last so its bytes win a same-address collision.
    for (int i = 0; i < 4; i++) begin
      if (we_a_i[i]) mem_q[addr_a_i][8*i +: 8] <= din_a_i[8*i +: 8];
    end
  end

  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline segment: pipeline register plus dual-port data RAM.
// Port A carries CPU loads/stores with store alignment and load extension; port B is a
// byte-writable debug port.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   en, clear                  stall (en=0 holds) and flush (bubble when en=1)
//   *_e                        EX-stage instruction fields and controls
//   *_mw                       registered fields, shaped load data and misalign flag
//   dbg_addr/wdata/we/rdata    debug access; rdata has one cycle latency
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int RAM_WORDS    = 4096,
  parameter int RD_W         = 5,
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [ADDR_W-1:0] alu_out_e,
  input  logic [31:0]       store_data_e,
  input  logic [RD_W-1:0]   rd_e,
  input  logic [ADDR_W-1:0] pc_e,
  input  logic              mem_read_e,
  input  logic              mem_write_e,
  input  logic [2:0]        mem_type_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              load_npc_e,
  output logic [ADDR_W-1:0] alu_out_mw,
  output logic [RD_W-1:0]   rd_mw,
  output logic [ADDR_W-1:0] pc_mw,
  output logic              reg_write_mw,
  output logic              mem_to_reg_mw,
  output logic              load_npc_mw,
  output logic [31:0]       load_data_mw,
  output logic              misalign_mw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_we,
  output logic [31:0]       dbg_rdata
);

  localparam int AW = $clog2(RAM_WORDS);

  // ---------------- EX side: alignment and store issue ----------------
  logic [1:0]  offset_e;
  logic        misalign_e;
  logic        store_fire;
  logic [3:0]  wea;
  logic [31:0] dina;
  logic [31:0] ram_douta;

  assign offset_e   = alu_out_e[1:0];
  assign misalign_e = MISALIGN_CHK & (mem_read_e | mem_write_e)
                      & is_misaligned(mem_type_e, offset_e);
  assign store_fire = mem_write_e & en & ~clear & rst_n & ~misalign_e;
  assign wea        = store_fire ? 4'(byte_mask(mem_type_e) << offset_e) : 4'b0000;
  assign dina       = store_data_e << {offset_e, 3'b000};

  data_ram_dp #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .addr_a_i (alu_out_e[AW+1:2]),
    .we_a_i   (wea),
    .din_a_i  (dina),
    .dout_a_o (ram_douta),
    .addr_b_i (dbg_addr[AW+1:2]),
    .we_b_i   (dbg_we),
    .din_b_i  (dbg_wdata),
    .dout_b_o (dbg_rdata)
  );

  // Byte offset and upper address bits are meaningless for word-wide debug accesses.
  logic unused_dbg_bits;
  assign unused_dbg_bits = ^{dbg_addr[ADDR_W-1:AW+2], dbg_addr[1:0]};

  // ---------------- pipeline register ----------------
  logic [ADDR_W-1:0] alu_out_d, alu_out_q;
  logic [RD_W-1:0]   rd_d, rd_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [2:0]        mem_type_d, mem_type_q;
  logic              reg_write_d, reg_write_q;
  logic              mem_to_reg_d, mem_to_reg_q;
  logic              load_npc_d, load_npc_q;
  logic              misalign_d, misalign_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_out_d    = alu_out_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    mem_type_d   = mem_type_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    load_npc_d   = load_npc_q;
    misalign_d   = misalign_q;
    if (en) begin
      if (clear) begin
        alu_out_d    = '0;
        rd_d         = '0;
        pc_d         = '0;
        mem_type_d   = '0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        load_npc_d   = 1'b0;
        misalign_d   = 1'b0;
      end else begin
        alu_out_d    = alu_out_e;
        rd_d         = rd_e;
        pc_d         = pc_e;
        mem_type_d   = mem_type_e;
        reg_write_d  = reg_write_e;
        mem_to_reg_d = mem_to_reg_e;
        load_npc_d   = load_npc_e;
        misalign_d   = misalign_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out_q    <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
      mem_type_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_npc_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      alu_out_q    <= alu_out_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      mem_type_q   <= mem_type_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_npc_q   <= load_npc_d;
      misalign_q   <= misalign_d;
    end
  end

  // ---------------- read-data hold ----------------
  // The RAM reads every cycle, so during a stall its output drifts; the word seen when the
  // stall began is parked in word_hold_q. A bubble shows a zero word.
  logic        stall_q, clear_q;
  logic [31:0] word_hold_q, shown_word;

  assign shown_word = stall_q ? word_hold_q : (clear_q ? 32'h0 : ram_douta);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      // Reset leaves a bubble in the stage, so the RAM output must be masked until the
      // first real capture.
      clear_q     <= 1'b1;
      word_hold_q <= '0;
    end else begin
      stall_q     <= ~en;
      clear_q     <= clear;
      word_hold_q <= shown_word;
    end
  end

  // ---------------- load shaping ----------------
  logic [31:0] shifted, load_data;

  always_comb begin
    shifted   = shown_word >> {alu_out_q[1:0], 3'b000};
    load_data = shifted;
    case (mem_type_q)
      MT_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      MT_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      MT_BU:   load_data = {24'h0, shifted[7:0]};
      MT_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    if (misalign_q) load_data = '0;
  end

  assign alu_out_mw    = alu_out_q;
  assign rd_mw         = rd_q;
  assign pc_mw         = pc_q;
  assign reg_write_mw  = reg_write_q;
  assign mem_to_reg_mw = mem_to_reg_q;
  assign load_npc_mw   = load_npc_q;
  assign misalign_mw   = misalign_q;
  assign load_data_mw  = load_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios followed by randomized traffic checked
// against a byte-addressed memory model.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, clear;
  logic [31:0] alu_out_e, store_data_e, pc_e;
  logic [4:0]  rd_e;
  logic        mem_read_e, mem_write_e, reg_write_e, mem_to_reg_e, load_npc_e;
  logic [2:0]  mem_type_e;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [3:0]  dbg_we;

  logic [31:0] alu_out_mw, pc_mw, load_data_mw, dbg_rdata;
  logic [4:0]  rd_mw;
  logic        reg_write_mw, mem_to_reg_mw, load_npc_mw, misalign_mw;

  logic [31:0] n_alu_out_mw, n_pc_mw, n_load_data_mw, n_dbg_rdata;
  logic [4:0]  n_rd_mw;
  logic        n_reg_write_mw, n_mem_to_reg_mw, n_load_npc_mw, n_misalign_mw;

  int vectors = 0;
  int miscompares = 0;

  logic [104:0] obs, exp_out;
  assign obs = {alu_out_mw, rd_mw, pc_mw, reg_write_mw, mem_to_reg_mw, load_npc_mw,
                load_data_mw, misalign_mw};

  // Reference memory: flat little-endian byte array, wrapping at the RAM size.
  localparam int MEM_BYTES = 4096 * 4;
  logic [7:0] ref_bytes [MEM_BYTES];

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .alu_out_e(alu_out_e), .store_data_e(store_data_e), .rd_e(rd_e), .pc_e(pc_e),
    .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .mem_type_e(mem_type_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .load_npc_e(load_npc_e),
    .alu_out_mw(alu_out_mw), .rd_mw(rd_mw), .pc_mw(pc_mw), .reg_write_mw(reg_write_mw),
    .mem_to_reg_mw(mem_to_reg_mw), .load_npc_mw(load_npc_mw), .load_data_mw(load_data_mw),
    .misalign_mw(misalign_mw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_rdata(dbg_rdata)
  );

  mem_wb_stage #(.MISALIGN_CHK(1'b0)) dut_nochk (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .alu_out_e(alu_out_e), .store_data_e(store_data_e), .rd_e(rd_e), .pc_e(pc_e),
    .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .mem_type_e(mem_type_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .load_npc_e(load_npc_e),
    .alu_out_mw(n_alu_out_mw), .rd_mw(n_rd_mw), .pc_mw(n_pc_mw),
    .reg_write_mw(n_reg_write_mw), .mem_to_reg_mw(n_mem_to_reg_mw),
    .load_npc_mw(n_load_npc_mw), .load_data_mw(n_load_data_mw),
    .misalign_mw(n_misalign_mw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_rdata(n_dbg_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] mt);
    if (mt == MT_B || mt == MT_BU) return 1;
    if (mt == MT_H || mt == MT_HU) return 2;
    return 4;
  endfunction

  function automatic bit ref_mis(input logic [31:0] addr, input logic [2:0] mt);
    return (addr % access_bytes(mt)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] mt);
    int n;
    logic [31:0] v;
    n = access_bytes(mt);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (32'(ref_bytes[(addr + k) % MEM_BYTES]) << (8 * k));
    if ((mt == MT_B || mt == MT_H) && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    return ref_load(addr - (addr % 4), MT_W);
  endfunction

  // Applies this cycle's memory side effects to the model, then advances one clock.
  task automatic step();
    for (int k = 0; k < 4; k++)
      if (dbg_we[k]) ref_bytes[((dbg_addr - (dbg_addr % 4)) + k) % MEM_BYTES] = 8'(dbg_wdata >> (8 * k));
    if (rst_n && en && !clear && mem_write_e && !ref_mis(alu_out_e, mem_type_e))
      for (int k = 0; k < access_bytes(mem_type_e); k++)
        ref_bytes[(alu_out_e + k) % MEM_BYTES] = 8'(store_data_e >> (8 * k));
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [2:0] mt,
                       input logic [31:0] addr, input logic [31:0] data);
    mem_read_e   = rd;
    mem_write_e  = wr;
    mem_type_e   = mt;
    alu_out_e    = addr;
    store_data_e = data;
    rd_e         = 5'($urandom);
    pc_e         = $urandom;
    reg_write_e  = rd;
    mem_to_reg_e = rd;
    load_npc_e   = 1'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clear = 1'b0;
    dbg_we = 4'h0; dbg_addr = 0; dbg_wdata = 0;
    issue(1, 0, MT_W, 32'h10, 0);
    step(); step();
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", obs); end
    rst_n = 1'b1; issue(0, 1, MT_W, 32'h20, 32'h1111_1111); step();
    rst_n = 1'b0; en = 1'b0; clear = 1'b1; issue(0, 1, MT_W, 32'h20, 32'h2222_2222); step();
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL reset_priority: got %h want 0", obs); end
    rst_n = 1'b1; en = 1'b1; clear = 1'b0; issue(1, 0, MT_W, 32'h20, 0); step();
    vectors++;
    if (load_data_mw !== 32'h1111_1111) begin
      miscompares++; $display("FAIL reset_blocks_store: got %h want 11111111", load_data_mw);
    end
  endtask

  task automatic test_word();
    issue(0, 1, MT_W, 32'h10, 32'hDEAD_BEEF); step();
    vectors++;
    if ({alu_out_mw, rd_mw, reg_write_mw} !== {32'h10, rd_e, 1'b0}) begin
      miscompares++; $display("FAIL sw_capture: got %h/%h/%b", alu_out_mw, rd_mw, reg_write_mw);
    end
    issue(1, 0, MT_W, 32'h10, 0); step();
    exp_out = {32'h10, rd_e, pc_e, 1'b1, 1'b1, load_npc_e, 32'hDEAD_BEEF, 1'b0};
    vectors++;
    if (obs !== exp_out) begin miscompares++; $display("FAIL lw_word: got %h want %h", obs, exp_out); end
  endtask

  task automatic test_extension();
    logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  types [4] = '{MT_B, MT_BU, MT_H, MT_HU};
    logic [31:0] wants [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, types[i], addrs[i], 0); step();
      vectors++;
      if (load_data_mw !== wants[i]) begin
        miscompares++; $display("FAIL ext_%0d: got %h want %h", i, load_data_mw, wants[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    issue(0, 1, MT_B, 32'h11, 32'h1234_5678); step();
    issue(1, 0, MT_W, 32'h10, 0); step();
    vectors++;
    if (load_data_mw !== 32'hDEAD_78EF) begin
      miscompares++; $display("FAIL sb_merge: got %h want dead78ef", load_data_mw);
    end
    issue(0, 1, MT_H, 32'h12, 32'hAAAA_5555); step();
    dbg_addr = 32'h10;
    issue(1, 0, MT_W, 32'h10, 0); step();
    vectors++;
    if (load_data_mw !== 32'h5555_78EF) begin
      miscompares++; $display("FAIL sh_merge: got %h want 555578ef", load_data_mw);
    end
    vectors++;
    if (dbg_rdata !== 32'h5555_78EF) begin
      miscompares++; $display("FAIL dbg_read: got %h want 555578ef", dbg_rdata);
    end
  endtask

  task automatic test_stall();
    logic [104:0] held;
    issue(1, 0, MT_W, 32'h10, 0); step();
    held = {32'h10, rd_e, pc_e, 1'b1, 1'b1, load_npc_e, 32'h5555_78EF, 1'b0};
    en = 1'b0;
    dbg_addr = 32'h10; dbg_wdata = 32'hCAFE_F00D; dbg_we = 4'hF;
    for (int j = 0; j < 3; j++) begin
      issue(0, 1, MT_W, 32'h10, 32'h9999_9999); step();
      dbg_we = 4'h0;
      vectors++;
      if (obs !== held) begin miscompares++; $display("FAIL stall_hold_%0d: got %h want %h", j, obs, held); end
    end
    en = 1'b1;
    issue(1, 0, MT_W, 32'h10, 0); step();
    vectors++;
    if (load_data_mw !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL stall_resume: got %h want cafef00d", load_data_mw);
    end
  endtask

  task automatic test_flush();
    logic [104:0] held;
    clear = 1'b1; issue(0, 1, MT_W, 32'h10, 32'h7777_7777); step();
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL flush_bubble: got %h want 0", obs); end
    clear = 1'b0; issue(1, 0, MT_W, 32'h10, 0); step();
    held = {32'h10, rd_e, pc_e, 1'b1, 1'b1, load_npc_e, 32'hCAFE_F00D, 1'b0};
    vectors++;
    if (obs !== held) begin miscompares++; $display("FAIL flush_no_store: got %h want %h", obs, held); end
    clear = 1'b1; en = 1'b0; issue(0, 0, MT_B, 32'h44, 0); step();
    vectors++;
    if (obs !== held) begin miscompares++; $display("FAIL flush_while_stalled: got %h want %h", obs, held); end
    clear = 1'b0; en = 1'b1;
  endtask

  task automatic test_misalign();
    issue(1, 0, MT_W, 32'h12, 0); step();
    vectors++;
    if ({misalign_mw, load_data_mw} !== {1'b1, 32'h0}) begin
      miscompares++; $display("FAIL lw_misalign: got %b/%h want 1/0", misalign_mw, load_data_mw);
    end
    vectors++;
    if (n_misalign_mw !== 1'b0) begin miscompares++; $display("FAIL nochk_lw: got %b want 0", n_misalign_mw); end
    issue(0, 1, MT_H, 32'h13, 32'hBBBB_BBBB); step();
    vectors++;
    if (misalign_mw !== 1'b1) begin miscompares++; $display("FAIL sh_misalign: got %b want 1", misalign_mw); end
    vectors++;
    if (n_misalign_mw !== 1'b0) begin miscompares++; $display("FAIL nochk_sh: got %b want 0", n_misalign_mw); end
    issue(1, 0, MT_W, 32'h10, 0); step();
    vectors++;
    if ({misalign_mw, load_data_mw} !== {1'b0, 32'hCAFE_F00D}) begin
      miscompares++; $display("FAIL sh_suppressed: got %b/%h want 0/cafef00d", misalign_mw, load_data_mw);
    end
    issue(0, 0, MT_W, 32'h12, 0); step();
    vectors++;
    if (misalign_mw !== 1'b0) begin miscompares++; $display("FAIL nonmem_flag: got %b want 0", misalign_mw); end
  endtask

  task automatic test_random();
    logic [2:0]  ld_types [5] = '{MT_B, MT_H, MT_W, MT_BU, MT_HU};
    logic [2:0]  st_types [3] = '{MT_B, MT_H, MT_W};
    logic [31:0] exp_dbg;
    en = 1'b1; clear = 1'b0;
    for (int w = 0; w < 64; w++) begin
      issue(0, 0, MT_W, 0, 0);
      dbg_addr = 32'(w * 4); dbg_wdata = $urandom; dbg_we = 4'hF;
      step();
    end
    dbg_we = 4'h0;
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [2:0] mt;
      logic [31:0] addr;
      bit mis;
      kind  = $urandom_range(0, 2);
      en    = (i == 0) || ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 9) == 0);
      mt    = (kind == 2) ? st_types[$urandom_range(0, 2)] : ld_types[$urandom_range(0, 4)];
      addr  = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      if (kind == 0 && ref_mis(addr, mt)) addr = addr - (addr % 4);
      issue(kind == 1, kind == 2, mt, addr, $urandom);
      dbg_addr = ($urandom & 32'hFFFF_C000) | $urandom_range(0, 255);
      exp_dbg  = ref_word(dbg_addr);
      if (en) begin
        if (clear) exp_out = '0;
        else begin
          mis = (kind != 0) && ref_mis(addr, mt);
          exp_out = {addr, rd_e, pc_e, reg_write_e, mem_to_reg_e, load_npc_e,
                     mis ? 32'h0 : ref_load(addr, mt), mis};
        end
      end
      step();
      vectors++;
      if (obs !== exp_out) begin miscompares++; $display("FAIL rand_%0d_out: got %h want %h", i, obs, exp_out); end
      vectors++;
      if (dbg_rdata !== exp_dbg) begin miscompares++; $display("FAIL rand_%0d_dbg: got %h want %h", i, dbg_rdata, exp_dbg); end
      vectors++;
      if (n_misalign_mw !== 1'b0) begin miscompares++; $display("FAIL rand_%0d_nochk: got %b want 0", i, n_misalign_mw); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clear = 1'b0;
    dbg_addr = 0; dbg_wdata = 0; dbg_we = 4'h0;
    issue(0, 0, MT_W, 0, 0);
    test_reset();
    test_word();
    test_extension();
    test_subword_store();
    test_stall();
    test_flush();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
